// File: rtl/flash_pkg.sv
// Shared types and constants for the NOR flash line-fill engine.
package flash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_HIT    = 2'd3
    } state_t;

    localparam int LINE_WORDS  = 4;
    localparam int HW_PER_WORD = 2;
    localparam int FLASH_AW    = 19;
    localparam int TAG_W       = FLASH_AW - 3;

    // First half-word address of a 16-byte line.
    function automatic logic [FLASH_AW-1:0] line_base(input logic [TAG_W-1:0] tag);
        return {tag, 3'd0};
    endfunction

endpackage

// File: rtl/flash_ctrl_if.sv
// Cache-miss request/return bus plus the parallel NOR flash pins of the line-fill engine.
// The slave side is flash_ctrl; the master side is the miss controller together with the flash part.
interface flash_ctrl_if;
    logic        req;
    logic [19:0] c_addr;
    logic        ack;
    logic        valid;
    logic [31:0] data;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic [18:0] flash_addr;
    logic [15:0] flash_rdata;

    modport master (
        output req, c_addr, flash_rdata,
        input  ack, valid, data, flash_ce_n, flash_oe_n, flash_addr
    );

    modport slave (
        input  req, c_addr, flash_rdata,
        output ack, valid, data, flash_ce_n, flash_oe_n, flash_addr
    );
endinterface

// File: rtl/flash_acc_timer.sv
// Wait-state down-counter: load sets WAIT_CYCLES, en counts down to 0 and holds; done when 0.
// Zero latency on done; no backpressure.
module flash_acc_timer #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic hclk,
    input  logic hreset_n,
    input  logic load,
    input  logic en,
    output logic done
);

    logic [3:0] cnt;

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= 4'(WAIT_CYCLES);
        end else if (en && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign done = (cnt == 4'd0);

endmodule

// File: rtl/flash_ctrl.sv
// Line-fill engine: one 16-byte line as eight timed half-word flash reads, returned as four 32-bit beats.
// First beat 2*(WAIT_CYCLES+1)+1 cycles after req; requests are held off (no ack) until req drops after a line.
// Optional one-line hit buffer under FLASH_LINE_BUF_EN.
module flash_ctrl
    import flash_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        hclk,
    input  logic        hreset_n,
    flash_ctrl_if.slave bus
);

    state_t             state;
    state_t             next_state;
    logic [2:0]         hw_cnt;
    logic [15:0]        lo_half;
    logic [TAG_W-1:0]   req_tag;
    logic               accept;
    logic               sample;
    logic               hit_start;
    logic               buf_hit;
    logic               last_beat;
    logic               tmr_done;
    logic               unused_nib;

    assign req_tag    = bus.c_addr[19:4];
    assign unused_nib = ^bus.c_addr[3:0];

    flash_acc_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .load     (accept | sample),
        .en       (state == ST_ACCESS),
        .done     (tmr_done)
    );

`ifdef FLASH_LINE_BUF_EN
    logic [TAG_W-1:0] buf_tag;
    logic             buf_vld;
    logic [31:0]      buf_dat [LINE_WORDS];
    logic [1:0]       rd_cnt;

    assign buf_hit   = buf_vld && (buf_tag == req_tag);
    assign last_beat = (rd_cnt == 2'(LINE_WORDS - 1));

    // The buffer is invalidated as soon as a new fill starts overwriting it.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            buf_tag <= '0;
            buf_vld <= 1'b0;
            rd_cnt  <= 2'd0;
        end else begin
            if (accept) begin
                buf_tag <= req_tag;
                buf_vld <= 1'b0;
            end
            if (sample && (hw_cnt == 3'd7)) begin
                buf_vld <= 1'b1;
            end
            if (hit_start) begin
                rd_cnt <= 2'd0;
            end else if (state == ST_HIT) begin
                rd_cnt <= rd_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (sample && hw_cnt[0]) begin
            buf_dat[hw_cnt[2:1]] <= {bus.flash_rdata, lo_half};
        end
    end
`else
    assign buf_hit   = 1'b0;
    assign last_beat = 1'b1;
`endif

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        sample     = 1'b0;
        hit_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    if (buf_hit) begin
                        hit_start  = 1'b1;
                        next_state = ST_HIT;
                    end else begin
                        accept     = 1'b1;
                        next_state = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (tmr_done) begin
                    sample = 1'b1;
                    if (hw_cnt == 3'd7) begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_HIT: begin
                if (last_beat) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.req) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Flash strobes are registered from next_state so they switch on the same edge as the state.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            bus.ack        <= 1'b0;
            bus.valid      <= 1'b0;
            bus.data       <= 32'd0;
            bus.flash_ce_n <= 1'b1;
            bus.flash_oe_n <= 1'b1;
            bus.flash_addr <= '0;
            hw_cnt         <= 3'd0;
            lo_half        <= 16'd0;
        end else begin
            bus.ack        <= accept | hit_start;
            bus.valid      <= 1'b0;
            bus.flash_ce_n <= (next_state != ST_ACCESS);
            bus.flash_oe_n <= (next_state != ST_ACCESS);
            if (accept) begin
                bus.flash_addr <= line_base(req_tag);
                hw_cnt         <= 3'd0;
            end
            if (sample) begin
                hw_cnt               <= hw_cnt + 3'd1;
                bus.flash_addr[2:0]  <= hw_cnt + 3'd1;
                if (!hw_cnt[0]) begin
                    lo_half <= bus.flash_rdata;
                end else begin
                    bus.data  <= {bus.flash_rdata, lo_half};
                    bus.valid <= 1'b1;
                end
            end
`ifdef FLASH_LINE_BUF_EN
            if (state == ST_HIT) begin
                bus.data  <= buf_dat[rd_cnt];
                bus.valid <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_flash_ctrl.sv
// Directed bench: two flash_ctrl instances (WAIT_CYCLES 3 and 0) driven in lockstep against a flash model
// whose read data equals the low 16 bits of the half-word address.
module tb_flash_ctrl;

    logic hclk;
    logic hreset_n;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] ed3;
    logic [31:0] ed0;

`ifdef FLASH_LINE_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    flash_ctrl_if bus3 ();
    flash_ctrl_if bus0 ();

    flash_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus3.slave)
    );

    flash_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus0.slave)
    );

    assign bus3.flash_rdata = bus3.flash_addr[15:0];
    assign bus0.flash_rdata = bus0.flash_addr[15:0];

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [19:0] a, input int k);
        logic [18:0] b;
        b = {a[19:4], 3'd0} + 19'(2 * k);
        return {b[15:0] + 16'd1, b[15:0]};
    endfunction

    // Checks one DUT in cycle c of a request (cycle 1 = the cycle after req is sampled).
    task automatic check_dut(input string nm, input int p, input int c, input logic [19:0] a,
                             input bit hit, input logic ack, input logic vld, input logic [31:0] dat,
                             input logic ce, input logic oe, input logic [18:0] fa,
                             inout logic [31:0] ed);
        bit exp_v;
        bit exp_ce;
        int k;
        if (hit) begin
            exp_v  = (c >= 2) && (c <= 5);
            k      = c - 2;
            exp_ce = 1'b1;
        end else begin
            exp_v  = (c > 1) && ((c - 1) % (2 * p) == 0) && ((c - 1) / (2 * p) <= 4);
            k      = (c - 1) / (2 * p) - 1;
            exp_ce = !(c < 1 + 8 * p);
        end
        if (exp_v) ed = exp_word(a, k);
        chk({nm, "_ack"},   32'(ack), 32'(c == 1));
        chk({nm, "_valid"}, 32'(vld), 32'(exp_v));
        chk({nm, "_data"},  dat, ed);
        chk({nm, "_ce_n"},  32'(ce), 32'(exp_ce));
        chk({nm, "_oe_n"},  32'(oe), 32'(exp_ce));
        if (!hit && (c <= 8 * p))
            chk({nm, "_faddr"}, 32'(fa), 32'({a[19:4], 3'((c - 1) / p)}));
    endtask

    task automatic run_fill(input logic [19:0] a, input bit hit, input int ncyc);
        bus3.req = 1'b1; bus3.c_addr = a;
        bus0.req = 1'b1; bus0.c_addr = a;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge hclk); #1;
            check_dut("w3", 4, c, a, hit, bus3.ack, bus3.valid, bus3.data,
                      bus3.flash_ce_n, bus3.flash_oe_n, bus3.flash_addr, ed3);
            check_dut("w0", 1, c, a, hit, bus0.ack, bus0.valid, bus0.data,
                      bus0.flash_ce_n, bus0.flash_oe_n, bus0.flash_addr, ed0);
        end
    endtask

    task automatic drop_req();
        bus3.req = 1'b0;
        bus0.req = 1'b0;
        @(posedge hclk); #1;
        chk("drop_ack3", 32'(bus3.ack), 32'd0);
        chk("drop_ack0", 32'(bus0.ack), 32'd0);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_ack3"},   32'(bus3.ack), 32'd0);
        chk({nm, "_valid3"}, 32'(bus3.valid), 32'd0);
        chk({nm, "_data3"},  bus3.data, 32'd0);
        chk({nm, "_ce3"},    32'(bus3.flash_ce_n), 32'd1);
        chk({nm, "_oe3"},    32'(bus3.flash_oe_n), 32'd1);
        chk({nm, "_fa3"},    32'(bus3.flash_addr), 32'd0);
        chk({nm, "_valid0"}, 32'(bus0.valid), 32'd0);
        chk({nm, "_data0"},  bus0.data, 32'd0);
        chk({nm, "_ce0"},    32'(bus0.flash_ce_n), 32'd1);
        chk({nm, "_fa0"},    32'(bus0.flash_addr), 32'd0);
    endtask

    initial begin
        hreset_n = 1'b0;
        bus3.req = 1'b0; bus3.c_addr = 20'h0;
        bus0.req = 1'b0; bus0.c_addr = 20'h0;
        ed3 = 32'd0;
        ed0 = 32'd0;
        repeat (3) @(posedge hclk);
        #1;
        check_reset_vals("rst");
        hreset_n = 1'b1;
        @(posedge hclk); #1;

        // Basic fill; req stays high well past the line to show no second ack.
        run_fill(20'h01230, 1'b0, 40);
        drop_req();
        run_fill(20'h00040, 1'b0, 36);
        drop_req();
        // Low nibble is ignored; buffer (if any) now holds 0x0004 so this misses.
        run_fill(20'h0123F, 1'b0, 36);
        drop_req();
        // Repeat of the same line: served from the buffer when it exists.
        run_fill(20'h01230, BUF_EN, 36);
        drop_req();
        run_fill(20'h01240, 1'b0, 36);
        drop_req();

        // Reset right after the second beat of the W=3 instance.
        run_fill(20'h00100, 1'b0, 17);
        hreset_n = 1'b0;
        bus3.req = 1'b0;
        bus0.req = 1'b0;
        #1;
        check_reset_vals("midrst");
        ed3 = 32'd0;
        ed0 = 32'd0;
        repeat (2) @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge hclk); #1;
            check_reset_vals("post_rst");
        end
        // Buffer valid is cleared by reset, so this goes to flash in every build.
        run_fill(20'h00100, 1'b0, 36);
        drop_req();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
